cordic_rotation_scheduler: RTL and testbench

CORDIC_ROTATION_SCHEDULER -- requirements
Module: cordic_rotation_scheduler

---
 rtl/cordic_rotation_scheduler.sv | 143 ++++++++++++++
 tb/tb_cordic_rotation_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_rotation_scheduler.sv
// cordic_rotation_scheduler
//   Shares one rotational CORDIC between NUM_REQ requesters. A round-robin
//   arbiter picks one job in IDLE, the operands are registered and presented
//   to the CORDIC with a single-cycle load strobe, and the result (or a
//   timeout error) is returned on a valid/ready response channel tagged with
//   the owner's id. Operands and results are passed through untouched.
//
// Ports
//   CLK, RST                 clock (rising edge), asynchronous active-low reset
//   req_valid / req_ready    per-requester request handshake (ready one-hot or zero)
//   req_x, req_y, req_z      packed operands, requester i at [i*WORD_LENGTH +: WORD_LENGTH]
//   cordic_enable            one-cycle load strobe to the CORDIC
//   cordic_xo/yo/zo          operands to the CORDIC, held until the job leaves WAIT
//   cordic_xn/yn, cordic_done  CORDIC results and result-valid
//   rsp_valid / rsp_ready    response handshake
//   rsp_id, rsp_x, rsp_y, rsp_err  response owner, results, timeout flag
//   busy                     high whenever a job is in flight
module cordic_rotation_scheduler #(
  parameter int WORD_LENGTH = 18,
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT     = 31,
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W      = $clog2(TIMEOUT + 1)
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic [NUM_REQ-1:0]                    req_valid,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic [NUM_REQ*WORD_LENGTH-1:0]        req_x,
  input  logic [NUM_REQ*WORD_LENGTH-1:0]        req_y,
  input  logic [NUM_REQ*WORD_LENGTH-1:0]        req_z,
  output logic                                  cordic_enable,
  output logic signed [WORD_LENGTH-1:0]         cordic_xo,
  output logic signed [WORD_LENGTH-1:0]         cordic_yo,
  output logic signed [WORD_LENGTH-1:0]         cordic_zo,
  input  logic signed [WORD_LENGTH-1:0]         cordic_xn,
  input  logic signed [WORD_LENGTH-1:0]         cordic_yn,
  input  logic                                  cordic_done,
  output logic                                  rsp_valid,
  input  logic                                  rsp_ready,
  output logic [ID_W-1:0]                       rsp_id,
  output logic signed [WORD_LENGTH-1:0]         rsp_x,
  output logic signed [WORD_LENGTH-1:0]         rsp_y,
  output logic                                  rsp_err,
  output logic                                  busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]  wait_cnt;
  logic              grant_hit;
  logic [ID_W-1:0]   grant_id;
  logic              accept;
  logic              timeout_hit;

  // Round-robin search: rr_ptr has top priority, then rr_ptr+1, ... wrapping.
  always_comb begin
    grant_hit = 1'b0;
    grant_id  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_hit && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        grant_hit = 1'b1;
        grant_id  = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  assign accept      = (state == S_IDLE) && grant_hit;
  // Counter holds the number of completed WAIT cycles, so the TIMEOUT-th
  // WAIT cycle is the one where it reads TIMEOUT-1.
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

  // FSM state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (cordic_done || timeout_hit) state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    req_ready     = '0;
    if (accept) req_ready[grant_id] = 1'b1;
    cordic_enable = (state == S_ISSUE);
    rsp_valid     = (state == S_RESP);
    busy          = (state != S_IDLE);
  end

  // Job capture, wait counter and result capture
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rr_ptr    <= '0;
      wait_cnt  <= '0;
      cordic_xo <= '0;
      cordic_yo <= '0;
      cordic_zo <= '0;
      rsp_id    <= '0;
      rsp_x     <= '0;
      rsp_y     <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        // Operand registers drive the CORDIC directly, so they stay stable
        // through WAIT where the CORDIC still needs Zo for sign correction.
        cordic_xo <= req_x[int'(grant_id)*WORD_LENGTH +: WORD_LENGTH];
        cordic_yo <= req_y[int'(grant_id)*WORD_LENGTH +: WORD_LENGTH];
        cordic_zo <= req_z[int'(grant_id)*WORD_LENGTH +: WORD_LENGTH];
        rsp_id    <= grant_id;
        rr_ptr    <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
      end
      if (state == S_ISSUE) begin
        wait_cnt <= '0;
      end else if (state == S_WAIT) begin
        // done wins over a coincident timeout
        if (cordic_done) begin
          rsp_x   <= cordic_xn;
          rsp_y   <= cordic_yn;
          rsp_err <= 1'b0;
        end else if (timeout_hit) begin
          rsp_x   <= '0;
          rsp_y   <= '0;
          rsp_err <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cordic_rotation_scheduler.sv
// Testbench for cordic_rotation_scheduler: a driver issues jobs with random
// operands, a CORDIC stub answers after a per-job delay, and a monitor pops
// expected responses from a scoreboard queue whenever rsp_valid is seen.
module tb_cordic_rotation_scheduler;
  localparam int W  = 18;
  localparam int NR = 4;
  localparam int TO = 31;

  typedef struct {
    int           id;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         err;
    int           lat;
    int           bp;
  } exp_t;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] z;
    logic [W-1:0] xn;
    logic [W-1:0] yn;
    int           dly;
  } stub_t;

  logic            CLK;
  logic            RST;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*W-1:0] req_x, req_y, req_z;
  logic            cordic_enable;
  logic [W-1:0]    cordic_xo, cordic_yo, cordic_zo;
  logic [W-1:0]    cordic_xn, cordic_yn;
  logic            cordic_done;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [W-1:0]    rsp_x, rsp_y;
  logic            rsp_err;
  logic            busy;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   issue_cyc = 0;
  int   rr = 0;
  exp_t  exp_q[$];
  stub_t stub_q[$];

  cordic_rotation_scheduler #(.WORD_LENGTH(W), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .cordic_enable(cordic_enable),
    .cordic_xo(cordic_xo), .cordic_yo(cordic_yo), .cordic_zo(cordic_zo),
    .cordic_xn(cordic_xn), .cordic_yn(cordic_yn), .cordic_done(cordic_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_err(rsp_err),
    .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference arbiter: first requesting index at or after rr, wrapping.
  function automatic int model_grant(input logic [NR-1:0] m);
    for (int k = 0; k < NR; k++)
      if (m[(rr + k) % NR]) return (rr + k) % NR;
    return 0;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_enable"}, cordic_enable, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_ops"}, {cordic_xo, cordic_yo, cordic_zo}, 0);
    chk({tag, "_rsp"}, {rsp_id, rsp_x, rsp_y, rsp_err}, 0);
  endtask

  // Present a job (mask of requesters valid), wait for the grant, register
  // the expected response and the stub's behaviour for the winning lane.
  task automatic run_job(input logic [NR-1:0] mask, input logic [W-1:0] x, y, z,
                         input int dly, input logic [W-1:0] xn, yn,
                         input int bp, input bit expect_rsp);
    int g, n;
    exp_t e;
    stub_t s;
    g = model_grant(mask);
    for (int i = 0; i < NR; i++) begin
      req_x[i*W +: W] = W'($urandom);
      req_y[i*W +: W] = W'($urandom);
      req_z[i*W +: W] = W'($urandom);
    end
    req_x[g*W +: W] = x;
    req_y[g*W +: W] = y;
    req_z[g*W +: W] = z;
    req_valid = mask;
    #1;
    n = 0;
    while (req_ready == '0 && n < 400) begin
      @(negedge CLK); #1;
      n++;
    end
    if (req_ready == '0) begin
      checks++; errors++;
      $display("FAIL grant_wait: got no req_ready expected grant of %0d", g);
      req_valid = '0;
      return;
    end
    chk("grant_onehot", req_ready, 64'(1) << g);
    s.x = x; s.y = y; s.z = z; s.xn = xn; s.yn = yn; s.dly = dly;
    stub_q.push_back(s);
    if (expect_rsp) begin
      e.id  = g;
      e.x   = (dly == 0) ? '0 : xn;
      e.y   = (dly == 0) ? '0 : yn;
      e.err = (dly == 0);
      e.lat = ((dly == 0) ? TO : dly) + 1;
      e.bp  = bp;
      exp_q.push_back(e);
    end
    @(negedge CLK);
    req_valid = '0;
    chk("enable_after_accept", cordic_enable, 1);
    chk("ready_in_issue", req_ready, 0);
    rr = (g + 1) % NR;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    if (exp_q.size() != 0 || busy) begin
      checks++; errors++;
      $display("FAIL drain: got %0d pending responses expected 0", exp_q.size());
    end
  endtask

  // CORDIC stub
  stub_t sc;
  initial begin
    cordic_done = 1'b0;
    cordic_xn = '0;
    cordic_yn = '0;
    forever begin
      @(negedge CLK);
      if (RST && cordic_enable) begin
        issue_cyc = cyc;
        if (stub_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL stub_issue: got unexpected cordic_enable expected none");
        end else begin
          sc = stub_q.pop_front();
          chk("ops_at_issue", {cordic_xo, cordic_yo, cordic_zo}, {sc.x, sc.y, sc.z});
          @(negedge CLK);
          chk("enable_one_cycle", cordic_enable, 0);
          if (sc.dly > 0) begin
            repeat (sc.dly - 1) @(negedge CLK);
            chk("ops_held_at_done", {cordic_xo, cordic_yo, cordic_zo}, {sc.x, sc.y, sc.z});
            cordic_done = 1'b1;
            cordic_xn = sc.xn;
            cordic_yn = sc.yn;
            // a stray done while in RESP must not disturb the response
            @(negedge CLK);
            cordic_xn = ~sc.xn;
            cordic_yn = ~sc.yn;
            @(negedge CLK);
            cordic_done = 1'b0;
            cordic_xn = '0;
            cordic_yn = '0;
          end
        end
      end
    end
  end

  // Response monitor
  exp_t cur;
  logic [W-1:0] snap_x, snap_y;
  logic [1:0]   snap_id;
  logic         snap_err;
  bit           in_rsp = 0;
  int           held = 0;
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        in_rsp = 0;
        rsp_ready = 1'b0;
      end else begin
        if (rsp_ready) begin
          in_rsp = 0;
          rsp_ready = 1'b0;
        end
        if (rsp_valid) begin
          if (!in_rsp) begin
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL rsp_unexpected: got rsp_id %0d expected no response", rsp_id);
              cur.bp = 0;
            end else begin
              cur = exp_q.pop_front();
              chk("rsp_id", rsp_id, cur.id);
              chk("rsp_x", rsp_x, cur.x);
              chk("rsp_y", rsp_y, cur.y);
              chk("rsp_err", rsp_err, cur.err);
              chk("rsp_latency", cyc - issue_cyc, cur.lat);
            end
            snap_x = rsp_x; snap_y = rsp_y; snap_id = rsp_id; snap_err = rsp_err;
            in_rsp = 1;
            held = 0;
          end else begin
            chk("rsp_stable", {rsp_id, rsp_x, rsp_y, rsp_err}, {snap_id, snap_x, snap_y, snap_err});
          end
          chk("ready_in_resp", req_ready, 0);
          rsp_ready = (held >= cur.bp);
          held++;
        end
      end
    end
  end

  initial begin
    RST = 1'b0;
    req_valid = '0;
    req_x = '0; req_y = '0; req_z = '0;
    repeat (3) @(negedge CLK);
    check_all_zero("in_reset");
    RST = 1'b1;
    @(negedge CLK);
    chk("idle_ready", req_ready, 0);

    // contention: all four requesters valid, expected grants 0,1,2,3,0
    for (int j = 0; j < 5; j++)
      run_job(4'hF, W'($urandom), W'($urandom), W'($urandom), $urandom_range(1, 10),
              W'($urandom), W'($urandom), 0, 1);

    // single job from requester 2 with a 12-cycle CORDIC
    run_job(4'b0100, 18'h00800, 18'h00000, 18'h00c90, 12, 18'h00000, 18'h00800, 1, 1);

    // backpressure of 5 cycles, next job queued behind it
    run_job(4'b0011, W'($urandom), W'($urandom), W'($urandom), 3, W'($urandom), W'($urandom), 5, 1);
    run_job(4'b1000, W'($urandom), W'($urandom), W'($urandom), 2, W'($urandom), W'($urandom), 0, 1);

    // timeout, then a normal job
    run_job(4'b0001, W'($urandom), W'($urandom), W'($urandom), 0, W'($urandom), W'($urandom), 2, 1);
    run_job(4'b0001, W'($urandom), W'($urandom), W'($urandom), 4, W'($urandom), W'($urandom), 0, 1);

    // done on the last permitted WAIT cycle, and one cycle before it
    run_job(4'b0110, W'($urandom), W'($urandom), W'($urandom), TO, W'($urandom), W'($urandom), 1, 1);
    run_job(4'b1001, W'($urandom), W'($urandom), W'($urandom), TO - 1, W'($urandom), W'($urandom), 0, 1);

    // random traffic
    for (int j = 0; j < 40; j++) begin
      int d;
      d = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TO);
      run_job(NR'($urandom_range(1, 15)), W'($urandom), W'($urandom), W'($urandom), d,
              W'($urandom), W'($urandom), $urandom_range(0, 3), 1);
    end

    // reset mid-WAIT discards the job and restarts arbitration at 0
    wait_idle();
    run_job(4'b0100, W'($urandom), W'($urandom), W'($urandom), 0, W'($urandom), W'($urandom), 0, 0);
    repeat (4) @(negedge CLK);
    chk("busy_in_wait", busy, 1);
    RST = 1'b0;
    #1;
    check_all_zero("mid_wait_reset");
    @(negedge CLK);
    RST = 1'b1;
    rr = 0;
    repeat (3) @(negedge CLK);
    chk("no_rsp_after_reset", rsp_valid, 0);
    run_job(4'hF, W'($urandom), W'($urandom), W'($urandom), 6, W'($urandom), W'($urandom), 0, 1);

    wait_idle();
    chk("pending_rsp", exp_q.size(), 0);
    chk("pending_issue", stub_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
